// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit serialiser (optional even parity, 1-2 stop bits).
// Start bit appears 2 cycles after an accepted push into an empty FIFO; TX_READY drops when full, rejected pushes pulse OVERFLOW.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    TX_DATA,
    input  logic                          TX_VALID,
    output logic                          TX_READY,
    output logic                          TXD,
    output logic                          TX_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      bit_idx_q;
    logic            stop_idx_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            txd_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            overflow_q;

    logic            push;
    logic            pop;
    logic            bit_end;
    logic            frame_end;
    logic [7:0]      head;

    // Ready depends only on registered count and reset, never on TX_VALID.
    assign TX_READY  = (count_q != CW'(FIFO_DEPTH)) && !RST;
    assign push      = TX_VALID && TX_READY;
    assign bit_end   = (timer_q == '0);
    assign frame_end = (state_q == S_STOP) && bit_end && (stop_idx_q == 1'(STOP_BITS - 1));
    assign pop       = (count_q != '0) && ((state_q == S_IDLE) || frame_end);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= TX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= TX_VALID && !TX_READY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q  <= S_START;
                        txd_q    <= 1'b0;
                        timer_q  <= TW'(CLK_DIV - 1);
                        shift_q  <= head;
                        parity_q <= ^head;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q   <= S_DATA;
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        timer_q   <= TW'(CLK_DIV - 1);
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q <= TW'(CLK_DIV - 1);
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_q <= S_PARITY;
                                txd_q   <= parity_q;
                            end else begin
                                state_q    <= S_STOP;
                                txd_q      <= 1'b1;
                                stop_idx_q <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q    <= S_STOP;
                        txd_q      <= 1'b1;
                        stop_idx_q <= 1'b0;
                        timer_q    <= TW'(CLK_DIV - 1);
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        timer_q <= TW'(CLK_DIV - 1);
                        if (frame_end) begin
                            // Chain straight into the next start bit when data is waiting.
                            if (pop) begin
                                state_q  <= S_START;
                                txd_q    <= 1'b0;
                                shift_q  <= head;
                                parity_q <= ^head;
                            end else begin
                                state_q <= S_IDLE;
                                txd_q   <= 1'b1;
                                timer_q <= '0;
                            end
                        end else begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign TXD        = txd_q;
    assign TX_BUSY    = (state_q != S_IDLE);
    assign FIFO_COUNT = count_q;
    assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance 8N1, one instance 8E2, both CLK_DIV=4, FIFO_DEPTH=4.
// TXD/TX_BUSY are logged every cycle so whole frames can be compared against expected bit sequences.
module tb_uart_tx_fifo;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] data_a, data_b;
    logic       vld_a, vld_b;
    logic       rdy_a, txd_a, busy_a, ovf_a;
    logic       rdy_b, txd_b, busy_b, ovf_b;
    logic [2:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int p;
    int acc;

    logic log_txd_a  [0:4095];
    logic log_busy_a [0:4095];
    logic log_txd_b  [0:4095];
    logic log_busy_b [0:4095];

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .TX_DATA(data_a), .TX_VALID(vld_a), .TX_READY(rdy_a),
        .TXD(txd_a), .TX_BUSY(busy_a), .FIFO_COUNT(cnt_a), .OVERFLOW(ovf_a)
    );

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .TX_DATA(data_b), .TX_VALID(vld_b), .TX_READY(rdy_b),
        .TXD(txd_b), .TX_BUSY(busy_b), .FIFO_COUNT(cnt_b), .OVERFLOW(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
        log_txd_a[cyc]  = txd_a;
        log_busy_a[cyc] = busy_a;
        log_txd_b[cyc]  = txd_b;
        log_busy_b[cyc] = busy_b;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx, input int par);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par != 0 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [7:0] b,
                               input int par, input int stops, input bit use_b);
        int len;
        len = (1 + 8 + par + stops) * DIV;
        for (int i = 0; i < len; i++) begin
            logic got;
            got = use_b ? log_txd_b[start+i] : log_txd_a[start+i];
            check($sformatf("%s bit%0d cyc%0d", tag, i / DIV, i), got, exp_bit(b, i / DIV, par));
        end
    endtask

    function automatic int busy_sum(input int from, input int to, input bit use_b);
        int s;
        s = 0;
        for (int i = from; i <= to; i++) s += use_b ? int'(log_busy_b[i]) : int'(log_busy_a[i]);
        return s;
    endfunction

    initial begin
        RST = 1'b1; vld_a = 1'b0; vld_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst txd", txd_a, 1);
        check("rst busy", busy_a, 0);
        check("rst count", cnt_a, 0);
        check("rst ready", rdy_a, 0);
        check("rst ovf", ovf_a, 0);
        check("rst txd b", txd_b, 1);
        check("rst ready b", rdy_b, 0);
        check("rst ovf b", ovf_b, 0);
        RST = 1'b0;
        tick();
        check("ready after rst", rdy_a, 1);
        check("ready after rst b", rdy_b, 1);

        // Single byte 0x55
        data_a = 8'h55; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        check("t2 count after push", cnt_a, 1);
        check("t2 txd before start", txd_a, 1);
        check("t2 busy before start", busy_a, 0);
        tick();
        p = cyc;
        check("t2 busy at start", busy_a, 1);
        check("t2 count after pop", cnt_a, 0);
        repeat (41) tick();
        check_frame("t2 0x55", p, 8'h55, 0, 1, 1'b0);
        check("t2 busy cycles", busy_sum(p - 1, p + 41, 1'b0), 40);
        check("t2 idle txd", txd_a, 1);
        check("t2 idle busy", busy_a, 0);

        // Back-to-back 0xA5, 0x3C
        data_a = 8'hA5; vld_a = 1'b1;
        tick();
        check("t3 count push1", cnt_a, 1);
        data_a = 8'h3C;
        tick();
        p = cyc;
        vld_a = 1'b0;
        check("t3 count push2+pop", cnt_a, 1);
        repeat (39) tick();
        check("t3 count last stop", cnt_a, 1);
        check("t3 txd last stop", txd_a, 1);
        tick();
        check("t3 count second pop", cnt_a, 0);
        check("t3 txd second start", txd_a, 0);
        repeat (41) tick();
        check_frame("t3 0xA5", p, 8'hA5, 0, 1, 1'b0);
        check_frame("t3 0x3C", p + 40, 8'h3C, 0, 1, 1'b0);
        check("t3 busy cycles", busy_sum(p, p + 81, 1'b0), 80);
        check("t3 idle busy", busy_a, 0);

        // Fill to full and overflow
        data_a = 8'h01; vld_a = 1'b1;
        tick();
        check("t4 count e0", cnt_a, 1);
        data_a = 8'h02;
        tick();
        p = cyc;
        check("t4 count e1", cnt_a, 1);
        data_a = 8'h03;
        tick();
        check("t4 count e2", cnt_a, 2);
        data_a = 8'h04;
        tick();
        check("t4 count e3", cnt_a, 3);
        data_a = 8'h05;
        tick();
        check("t4 count full", cnt_a, 4);
        check("t4 ready full", rdy_a, 0);
        check("t4 ovf before", ovf_a, 0);
        data_a = 8'h06;
        tick();
        vld_a = 1'b0;
        check("t4 ovf pulse", ovf_a, 1);
        check("t4 count after reject", cnt_a, 4);
        tick();
        check("t4 ovf cleared", ovf_a, 0);
        check("t4 ready still full", rdy_a, 0);
        repeat (196) tick();
        for (int k = 0; k < 5; k++) begin
            check_frame($sformatf("t4 byte%0d", k + 1), p + 40 * k, 8'(k + 1), 0, 1, 1'b0);
        end
        check("t4 busy cycles", busy_sum(p, p + 201, 1'b0), 200);
        check("t4 final count", cnt_a, 0);
        check("t4 final ready", rdy_a, 1);
        check("t4 final txd", txd_a, 1);

        // Parity + two stop bits on the second instance
        data_b = 8'h07; vld_b = 1'b1;
        tick();
        vld_b = 1'b0;
        check("t5 count b", cnt_b, 1);
        tick();
        p = cyc;
        check("t5 busy b", busy_b, 1);
        repeat (49) tick();
        check_frame("t5 0x07", p, 8'h07, 1, 2, 1'b1);
        check("t5 busy cycles", busy_sum(p - 1, p + 49, 1'b1), 48);
        check("t5 idle txd b", txd_b, 1);

        // Reset during data bit 3 with two bytes queued
        data_a = 8'h00; vld_a = 1'b1;
        tick();
        data_a = 8'hFF;
        tick();
        p = cyc;
        data_a = 8'h81;
        tick();
        vld_a = 1'b0;
        check("t6 queued", cnt_a, 2);
        repeat (15) tick();
        check("t6 txd bit3", txd_a, 0);
        check("t6 busy bit3", busy_a, 1);
        RST = 1'b1;
        tick();
        check("t6 txd after rst", txd_a, 1);
        check("t6 count after rst", cnt_a, 0);
        check("t6 busy after rst", busy_a, 0);
        check("t6 ready in rst", rdy_a, 0);
        RST = 1'b0;
        tick();
        check("t6 ready after rst", rdy_a, 1);
        repeat (100) tick();
        acc = 0;
        for (int i = p + 17; i <= cyc; i++) acc += (log_txd_a[i] == 1'b0) ? 1 : 0;
        check("t6 no low txd", acc, 0);
        check("t6 no busy", busy_sum(p + 17, cyc, 1'b0), 0);
        check("t6 final count", cnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
